// File: rtl/bayer_demosaic.sv
// bayer_demosaic: streaming bilinear Bayer-to-RGB interpolation.
// Two line buffers feed a 3x3 window. Each accepted input pixel yields one RGB
// pixel centred one row and one column behind it, after two cycles of latency.
module bayer_demosaic #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int PIX_W  = 12,
  parameter int BAYER  = 0
) (
  input  logic             pclk,
  input  logic             rst_n_i,
  input  logic [15:0]      row_i,
  input  logic [15:0]      col_i,
  input  logic             valid_i,
  input  logic [PIX_W-1:0] pixel_i,
  output logic [15:0]      row_o,
  output logic [15:0]      col_o,
  output logic             valid_o,
  output logic [PIX_W-1:0] red_o,
  output logic [PIX_W-1:0] green_o,
  output logic [PIX_W-1:0] blue_o
);

  localparam int         AW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int         SW    = PIX_W + 2;
  localparam logic [1:0] PHASE = 2'(BAYER);

  // Line buffers: lb0 = previous row, lb1 = the row before that
  logic [PIX_W-1:0] r_lb0 [WIDTH];
  logic [PIX_W-1:0] r_lb1 [WIDTH];
  logic [AW-1:0]    w_addr;
  logic [PIX_W-1:0] w_lb0_rd;
  logic [PIX_W-1:0] w_lb1_rd;
  logic             w_emit;

  // 3x3 window: [row 0 = top .. 2 = bottom][col 0 = left .. 2 = right]
  logic [PIX_W-1:0] r_win [3][3];

  // Stage 1: centre coordinates and emission qualifier
  logic             r_v1;
  logic             r_bord1;
  logic [15:0]      r_row1;
  logic [15:0]      r_col1;

  // Stage 2: interpolated colour
  logic             r_v2;
  logic [15:0]      r_row2;
  logic [15:0]      r_col2;
  logic [PIX_W-1:0] r_red2;
  logic [PIX_W-1:0] r_grn2;
  logic [PIX_W-1:0] r_blu2;

  // Combinational interpolation
  logic [1:0]       w_site;
  logic [SW-1:0]    w_cross;
  logic [SW-1:0]    w_diag;
  logic [SW-1:0]    w_ew;
  logic [SW-1:0]    w_ns;
  logic [PIX_W-1:0] w_red;
  logic [PIX_W-1:0] w_grn;
  logic [PIX_W-1:0] w_blu;

  assign w_addr   = col_i[AW-1:0];
  assign w_lb0_rd = r_lb0[w_addr];
  assign w_lb1_rd = r_lb1[w_addr];
  // Centre (row_i-1, col_i-1) must exist and lie inside the frame
  assign w_emit   = valid_i && (row_i != 16'd0) && (col_i != 16'd0) &&
                    (row_i < 16'(HEIGHT)) && (col_i < 16'(WIDTH));

  // Line buffer update: read-before-write, rows age lb0 -> lb1 (no reset needed)
  always_ff @(posedge pclk) begin
    if (rst_n_i && valid_i) begin
      r_lb1[w_addr] <= w_lb0_rd;
      r_lb0[w_addr] <= pixel_i;
    end
  end

  // Window shift and stage-1 centre tracking; window moves only on accepted pixels
  always_ff @(posedge pclk) begin
    if (!rst_n_i) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= '0;
        end
      end
      r_v1    <= 1'b0;
      r_bord1 <= 1'b0;
      r_row1  <= 16'd0;
      r_col1  <= 16'd0;
    end else begin
      r_v1 <= w_emit;
      if (valid_i) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= w_lb1_rd;
        r_win[1][2] <= w_lb0_rd;
        r_win[2][2] <= pixel_i;
        r_row1      <= row_i - 16'd1;
        r_col1      <= col_i - 16'd1;
        // Row-0 / col-0 centres also cover stale window data after a column wrap
        r_bord1     <= (row_i == 16'd1) || (col_i == 16'd1);
      end
    end
  end

  assign w_site  = {r_row1[0], r_col1[0]} ^ PHASE;
  assign w_cross = {2'b00, r_win[0][1]} + {2'b00, r_win[2][1]} +
                   {2'b00, r_win[1][0]} + {2'b00, r_win[1][2]};
  assign w_diag  = {2'b00, r_win[0][0]} + {2'b00, r_win[0][2]} +
                   {2'b00, r_win[2][0]} + {2'b00, r_win[2][2]};
  assign w_ew    = {2'b00, r_win[1][0]} + {2'b00, r_win[1][2]};
  assign w_ns    = {2'b00, r_win[0][1]} + {2'b00, r_win[2][1]};

  // Bilinear interpolation selected by CFA site type; border centres give black
  always_comb begin
    w_red = '0;
    w_grn = '0;
    w_blu = '0;
    if (r_bord1) begin
      w_red = '0;
      w_grn = '0;
      w_blu = '0;
    end else begin
      case (w_site)
        2'd0: begin  // R site
          w_red = r_win[1][1];
          w_grn = w_cross[PIX_W+1:2];
          w_blu = w_diag[PIX_W+1:2];
        end
        2'd1: begin  // G on R row
          w_grn = r_win[1][1];
          w_red = w_ew[PIX_W:1];
          w_blu = w_ns[PIX_W:1];
        end
        2'd2: begin  // G on B row
          w_grn = r_win[1][1];
          w_blu = w_ew[PIX_W:1];
          w_red = w_ns[PIX_W:1];
        end
        2'd3: begin  // B site
          w_blu = r_win[1][1];
          w_grn = w_cross[PIX_W+1:2];
          w_red = w_diag[PIX_W+1:2];
        end
        default: begin
          w_red = '0;
          w_grn = '0;
          w_blu = '0;
        end
      endcase
    end
  end

  // Stage 2: capture interpolated pixel
  always_ff @(posedge pclk) begin
    if (!rst_n_i) begin
      r_v2   <= 1'b0;
      r_row2 <= 16'd0;
      r_col2 <= 16'd0;
      r_red2 <= '0;
      r_grn2 <= '0;
      r_blu2 <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_row2 <= r_row1;
        r_col2 <= r_col1;
        r_red2 <= w_red;
        r_grn2 <= w_grn;
        r_blu2 <= w_blu;
      end
    end
  end

  // Output register: values hold between pulses, valid strobes for one cycle
  always_ff @(posedge pclk) begin
    if (!rst_n_i) begin
      valid_o <= 1'b0;
      row_o   <= 16'd0;
      col_o   <= 16'd0;
      red_o   <= '0;
      green_o <= '0;
      blue_o  <= '0;
    end else begin
      valid_o <= r_v2;
      if (r_v2) begin
        row_o   <= r_row2;
        col_o   <= r_col2;
        red_o   <= r_red2;
        green_o <= r_grn2;
        blue_o  <= r_blu2;
      end
    end
  end

endmodule

// File: tb/tb_bayer_demosaic.sv
// Bench for bayer_demosaic: two instances (RGGB and BGGR phase) share one input
// stream; a frame-level model predicts every output cycle.
module tb_bayer_demosaic;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PW = 12;

  logic          pclk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   row_in = 16'd0;
  logic [15:0]   col_in = 16'd0;
  logic          vin = 1'b0;
  logic [PW-1:0] pix = '0;

  logic [15:0]   row0, col0, row3, col3;
  logic          vo0, vo3;
  logic [PW-1:0] red0, grn0, blu0, red3, grn3, blu3;

  int img [H][W];
  int checks = 0;
  int errors = 0;
  int pulses = 0;

  typedef struct packed {
    logic        v;
    logic        z;
    logic [15:0] row;
    logic [15:0] col;
    logic [11:0] r0, g0, b0, r3, g3, b3;
  } exp_t;

  always #5 pclk = ~pclk;

  bayer_demosaic #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW), .BAYER(0)) dut0 (
    .pclk(pclk), .rst_n_i(rst_n), .row_i(row_in), .col_i(col_in),
    .valid_i(vin), .pixel_i(pix), .row_o(row0), .col_o(col0),
    .valid_o(vo0), .red_o(red0), .green_o(grn0), .blue_o(blu0));

  bayer_demosaic #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW), .BAYER(3)) dut3 (
    .pclk(pclk), .rst_n_i(rst_n), .row_i(row_in), .col_i(col_in),
    .valid_i(vin), .pixel_i(pix), .row_o(row3), .col_o(col3),
    .valid_o(vo3), .red_o(red3), .green_o(grn3), .blue_o(blu3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Bilinear reconstruction of centre (r,c) straight from the frame image
  function automatic void model(input int r, input int c, input int b,
                                output int rr, output int gg, output int bb);
    int cc, n, s, e, w, d, p;
    rr = 0; gg = 0; bb = 0;
    if (r == 0 || c == 0) return;
    cc = img[r][c];
    n  = img[r-1][c];
    s  = img[r+1][c];
    w  = img[r][c-1];
    e  = img[r][c+1];
    d  = img[r-1][c-1] + img[r-1][c+1] + img[r+1][c-1] + img[r+1][c+1];
    p  = ((r % 2) * 2 + (c % 2)) ^ b;
    case (p)
      0:       begin rr = cc; gg = (n + s + e + w) / 4; bb = d / 4; end
      3:       begin bb = cc; gg = (n + s + e + w) / 4; rr = d / 4; end
      1:       begin gg = cc; rr = (e + w) / 2; bb = (n + s) / 2; end
      default: begin gg = cc; bb = (e + w) / 2; rr = (n + s) / 2; end
    endcase
  endfunction

  task automatic pin(input string name, input int r, input int c, input int b,
                     input int er, input int eg, input int eb);
    int rr, gg, bb;
    model(r, c, b, rr, gg, bb);
    chk({name, "_r"}, rr, er);
    chk({name, "_g"}, gg, eg);
    chk({name, "_b"}, bb, eb);
  endtask

  // mode 0: flat v; 1: mosaic with layout phase v; 2: impulse; 3: random
  task automatic set_img(input int mode, input int v);
    int p;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        p = ((r % 2) * 2 + (c % 2)) ^ v;
        case (mode)
          0:       img[r][c] = v;
          1:       img[r][c] = (p == 0) ? 200 : ((p == 3) ? 50 : 100);
          2:       img[r][c] = (r == 2 && c == 2) ? 255 : 0;
          default: img[r][c] = int'($urandom_range(0, 4095));
        endcase
      end
    end
  endtask

  // Stream the current image; optionally pulse reset (with valid high) at (rr,rc)
  task automatic send_frame(input int gap, input int rr, input int rc);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        @(posedge pclk); #1;
        row_in = 16'(r);
        col_in = 16'(c);
        pix    = 12'(img[r][c]);
        vin    = 1'b1;
        if (r == rr && c == rc) begin
          rst_n = 1'b0;
          @(posedge pclk); #1;
          rst_n = 1'b1;
          vin   = 1'b0;
          return;
        end
        repeat (gap - 1) begin
          @(posedge pclk); #1;
          vin = 1'b0;
        end
      end
    end
    @(posedge pclk); #1;
    vin = 1'b0;
  endtask

  task automatic run_frame(input string name, input int gap);
    pulses = 0;
    send_frame(gap, -1, -1);
    repeat (5) @(posedge pclk);
    #1;
    chk({name, "_count"}, pulses, 35);
  endtask

  // Per-cycle compare: an input seen before edge N is due after edge N+2
  initial begin
    exp_t d1, d2, d3, ne;
    int rr, gg, bb;
    d1 = '0; d2 = '0; d3 = '0;
    @(posedge pclk);
    forever begin
      @(negedge pclk);
      if (vo0 === 1'b1) pulses++;
      chk("valid0", vo0, d3.v);
      chk("valid3", vo3, d3.v);
      if (d3.v || d3.z) begin
        chk("row0", row0, d3.row);
        chk("col0", col0, d3.col);
        chk("red0", red0, d3.r0);
        chk("grn0", grn0, d3.g0);
        chk("blu0", blu0, d3.b0);
        chk("row3", row3, d3.row);
        chk("col3", col3, d3.col);
        chk("red3", red3, d3.r3);
        chk("grn3", grn3, d3.g3);
        chk("blu3", blu3, d3.b3);
      end
      d3 = d2;
      d2 = d1;
      if (!rst_n) begin
        d3 = '0;
        d3.z = 1'b1;
        d2 = '0;
        d1 = '0;
      end else begin
        ne = '0;
        if (vin && row_in >= 16'd1 && col_in >= 16'd1) begin
          ne.v   = 1'b1;
          ne.row = row_in - 16'd1;
          ne.col = col_in - 16'd1;
          model(int'(row_in) - 1, int'(col_in) - 1, 0, rr, gg, bb);
          ne.r0 = 12'(rr); ne.g0 = 12'(gg); ne.b0 = 12'(bb);
          model(int'(row_in) - 1, int'(col_in) - 1, 3, rr, gg, bb);
          ne.r3 = 12'(rr); ne.g3 = 12'(gg); ne.b3 = 12'(bb);
        end
        d1 = ne;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    rst_n = 1'b1;

    set_img(0, 100);
    pin("flat_border", 0, 3, 0, 0, 0, 0);
    pin("flat_int", 2, 2, 0, 100, 100, 100);
    run_frame("flat", 1);

    set_img(1, 0);
    pin("rggb_g", 2, 3, 0, 200, 100, 50);
    pin("rggb_b", 3, 3, 0, 200, 100, 50);
    run_frame("rggb", 1);

    set_img(1, 3);
    pin("bggr_b", 2, 2, 3, 200, 100, 50);
    pin("bggr_g", 3, 2, 3, 200, 100, 50);
    run_frame("bggr", 1);

    set_img(2, 0);
    pin("imp22", 2, 2, 0, 255, 0, 0);
    pin("imp23", 2, 3, 0, 127, 0, 0);
    pin("imp33", 3, 3, 0, 63, 0, 0);
    pin("imp21", 2, 1, 0, 127, 0, 0);
    pin("imp12", 1, 2, 0, 127, 0, 0);
    run_frame("impulse", 1);

    set_img(0, 100);
    run_frame("gapped", 4);

    send_frame(1, 3, 3);
    repeat (3) @(posedge pclk);
    run_frame("post_reset", 1);

    set_img(0, 4095);
    pin("max_int", 2, 2, 0, 4095, 4095, 4095);
    run_frame("max", 1);

    for (int f = 0; f < 3; f++) begin
      set_img(3, 0);
      run_frame("random", int'($urandom_range(1, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bayer_demosaic.md
Name: bayer_demosaic

Overview:
- Streaming bilinear Bayer-to-RGB stage. It sits directly downstream of conv_net and upstream of VGA_PARAM's read path.
- Consumes the raster pixel stream (row, col, valid, pixel) and keeps two line buffers plus a 3x3 window.
- Emits one interpolated RGB pixel per accepted input pixel, centred one row and one column behind the input.

Parameters:
- WIDTH, 640, image width in pixels; also the line buffer depth.
- HEIGHT, 480, image height in pixels.
- PIX_W, 12, bit width of the input pixel and of each output colour channel.
- BAYER, 0, CFA phase at (row 0, col 0): 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR.

Ports:
- pclk  in  1  clock; all logic on the rising edge.
- rst_n_i  in  1  reset, synchronous, active-low.
- row_i  in  16  row of the incoming pixel.
- col_i  in  16  column of the incoming pixel.
- valid_i  in  1  pixel_i/row_i/col_i are valid this cycle.
- pixel_i  in  PIX_W  raw Bayer sample.
- row_o  out  16  row of the output (centre) pixel.
- col_o  out  16  column of the output (centre) pixel.
- valid_o  out  1  output valid strobe.
- red_o  out  PIX_W  interpolated red.
- green_o  out  PIX_W  interpolated green.
- blue_o  out  PIX_W  interpolated blue.

Behaviour:
- Reset (rst_n_i=0 at an edge): valid_o, row_o, col_o, red_o, green_o, blue_o, window registers and pipeline valids all go to 0. Line buffer RAM is not cleared and needs no clearing.
- Input stream: raster order, col 0..WIDTH-1 within each row, rows 0..HEIGHT-1. Arbitrary idle gaps between valid_i pulses are allowed (CLKS_PER_PIXEL >= 1). No backpressure.
- Line buffers:
  - lb0 holds the previous row, lb1 the row before that; both are addressed by col_i.
  - On valid_i, read-before-write at address col_i: lb1 <= lb0 old value, lb0 <= pixel_i.
  - The window shifts one column left and loads the new right column {lb1 old, lb0 old, pixel_i}.
  - All state advances only on valid_i.
- Emission: an output is produced only for input pixels with row_i>=1 and col_i>=1. Its centre is (row_i-1, col_i-1). Centres in row HEIGHT-1 or column WIDTH-1 are never emitted.
- Latency: exactly 2 cycles. valid_i sampled at edge N gives valid_o high for one cycle after edge N+2, with row_o/col_o equal to the centre coordinates.
- Border: if the centre is in row 0 or column 0, red_o, green_o and blue_o are all 0 while valid_o still asserts. This also masks stale window contents after a column wrap.
- Site type: taken from centre parity (r&1, c&1) XOR BAYER phase.
  - R site: R=C; G=(N+S+E+W)>>2; B=(NE+NW+SE+SW)>>2.
  - B site: B=C; G=(N+S+E+W)>>2; R=(diagonals)>>2.
  - G site on an R row: G=C; R=(E+W)>>1; B=(N+S)>>1.
  - G site on a B row: G=C; B=(E+W)>>1; R=(N+S)>>1.
- Arithmetic: sums are carried in PIX_W+2 bits, then shifted right with truncation (no rounding). Results always fit in PIX_W bits, so no saturation is needed.
- Outputs are registered. Between pulses, row_o/col_o/rgb hold their last value and valid_o=0.
- Reset mid-frame: pipeline contents are discarded and valid_o stays 0 until new valid_i arrive.
  - Output resumes 2 cycles after the first qualifying input.
  - Results are correct from the next frame's row 2 onward; rows emitted before two full post-reset rows have been written are don't-care.
- Simultaneous valid_i with rst_n_i=0: reset wins and the input is dropped.

Test Plan (WIDTH=8, HEIGHT=6, PIX_W=12 unless stated):
- Flat frame, all pixels 100, BAYER=0, valid every cycle -> exactly 35 valid_o pulses, centres (0..4, 0..6). Row-0/col-0 centres give RGB (0,0,0); all others give (100,100,100). Latency 2 cycles.
- RGGB mosaic with R sites 200, G 100, B 50 -> every non-border output is (200,100,50). Repeat with BAYER=3 and a BGGR-laid-out mosaic -> same result.
- Impulse: 255 at (2,2), 0 elsewhere, BAYER=0 ->
  - (2,2): (255,0,0)
  - (2,3): R=127, G=0, B=0
  - (3,3): R=63, G=0, B=0
  - (2,1): R=127
  - (1,2): R=127
- Gapped stream: same flat frame with valid_i every 4th cycle -> identical outputs and count. Each valid_o follows its input by 2 cycles, and no valid_o occurs in the gaps.
- Reset: assert rst_n_i=0 for one cycle mid-row 3 with valid_i=1 -> all outputs 0 on the next cycle. The following full frame matches the flat-frame expectations.
- Max value: all pixels 4095 -> interior (4095,4095,4095), confirming no overflow.
